mem_blk_arbiter: RTL and testbench

MEM_BLK_ARBITER -- requirements
Module: mem_blk_arbiter

---
 rtl/mem_blk_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_blk_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_blk_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single block memory.
// Round-robin on contention, one transfer at a time, watchdog aborts a stalled memory.
module mem_blk_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         i_req,
  input  logic         i_we,
  input  logic [31:0]  i_addr,
  input  logic [255:0] i_wdata,
  output logic         i_done,
  output logic [255:0] i_rdata,
  input  logic         d_req,
  input  logic         d_we,
  input  logic [31:0]  d_addr,
  input  logic [255:0] d_wdata,
  output logic         d_done,
  output logic [255:0] d_rdata,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [255:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [255:0] mem_rdata,
  output logic         err,
  output logic         busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

  logic [1:0]   state_q, state_d;
  logic         last_grant_q, last_grant_d;  // 0 = I side, 1 = D side
  logic         mem_req_q, mem_req_d;
  logic         mem_we_q, mem_we_d;
  logic [31:0]  mem_addr_q, mem_addr_d;
  logic [255:0] mem_wdata_q, mem_wdata_d;
  logic         i_done_q, i_done_d;
  logic         d_done_q, d_done_d;
  logic [255:0] i_rdata_q, i_rdata_d;
  logic [255:0] d_rdata_q, d_rdata_d;
  logic         err_q, err_d;
  logic [TW-1:0] wd_q, wd_d;
  logic         grant_d_side;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    err_d        = err_q;
    wd_d         = wd_q;
    grant_d_side = (i_req && d_req) ? ~last_grant_q : d_req;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d      = grant_d_side ? GNT_D : GNT_I;
          last_grant_d = grant_d_side;
          mem_req_d    = 1'b1;
          mem_we_d     = grant_d_side ? d_we    : i_we;
          mem_addr_d   = grant_d_side ? d_addr  : i_addr;
          mem_wdata_d  = grant_d_side ? d_wdata : i_wdata;
          wd_d         = '0;
        end
      end
      GNT_I, GNT_D: begin
        // An ack arriving on the timeout cycle still completes normally.
        if (mem_ack || wd_q == WD_LAST) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          i_done_d  = (state_q == GNT_I);
          d_done_d  = (state_q == GNT_D);
          if (!mem_ack) begin
            err_d = 1'b1;
          end else if (state_q == GNT_I) begin
            i_rdata_d = mem_rdata;
          end else begin
            d_rdata_d = mem_rdata;
          end
        end else begin
          wd_d = wd_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      err_q        <= 1'b0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      err_q        <= err_d;
      wd_q         <= wd_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_blk_arbiter.sv
// Directed and randomized checks of mem_blk_arbiter against a transaction-level model
// (fair alternation on contention, ack latency vs. timeout, sticky error, held read data).
module tb_mem_blk_arbiter;

  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_req = 1'b0, i_we = 1'b0;
  logic [31:0]  i_addr = '0;
  logic [255:0] i_wdata = '0;
  logic         i_done;
  logic [255:0] i_rdata;
  logic         d_req = 1'b0, d_we = 1'b0;
  logic [31:0]  d_addr = '0;
  logic [255:0] d_wdata = '0;
  logic         d_done;
  logic [255:0] d_rdata;
  logic         mem_req, mem_we;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic         mem_ack = 1'b0;
  logic [255:0] mem_rdata = '0;
  logic         err, busy;

  int checks = 0;
  int errors = 0;

  // Reference model: who was served last, sticky error, last delivered blocks.
  bit           m_last;
  logic         m_err;
  logic [255:0] m_irdata, m_drdata;

  always #5 clk = ~clk;

  mem_blk_arbiter #(.TIMEOUT(TO), .TW(7)) dut (
    .CLK(clk), .RESET(rst_n),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .err(err), .busy(busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic raise_i();
    i_req = 1'b1; i_we = 1'($urandom); i_addr = $urandom; i_wdata = rand256();
  endtask

  task automatic raise_d();
    d_req = 1'b1; d_we = 1'($urandom); d_addr = $urandom; d_wdata = rand256();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 256'h0);
    chk("rst_done", {i_done, d_done}, 2'b00);
    chk("rst_i_rdata", i_rdata, 256'h0);
    chk("rst_d_rdata", d_rdata, 256'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    m_last = 1'b0; m_err = 1'b0; m_irdata = '0; m_drdata = '0;
  endtask

  // One complete transfer starting in an IDLE cycle. k = cycles after mem_req rises
  // before the ack is offered (k >= TO means the memory never answers in time).
  task automatic xfer(input int k, input logic [255:0] rd, input bit drop_mid,
                      input bit spurious, output logic [31:0] first_addr);
    bit g;
    logic [31:0] ea;
    logic ewe;
    logic [255:0] ewd;
    int hi;
    bit stable;
    bit timed_out;
    g   = (i_req && d_req) ? !m_last : d_req;
    m_last = g;
    ea  = g ? d_addr : i_addr;
    ewe = g ? d_we : i_we;
    ewd = g ? d_wdata : i_wdata;
    tick();
    first_addr = mem_addr;
    chk("grant_req", mem_req, 1'b1);
    chk("grant_addr", mem_addr, ea);
    chk("grant_we", mem_we, ewe);
    chk("grant_wdata", mem_wdata, ewd);
    chk("grant_busy", busy, 1'b1);
    hi = 0;
    stable = 1'b1;
    while (mem_req === 1'b1 && hi < TO + 4) begin
      if (mem_addr !== ea || mem_we !== ewe || mem_wdata !== ewd) stable = 1'b0;
      if (hi == k) begin mem_ack = 1'b1; mem_rdata = rd; end
      if (drop_mid && hi == 1) begin if (g) d_req = 1'b0; else i_req = 1'b0; end
      tick();
      mem_ack = 1'b0;
      hi++;
    end
    timed_out = (k > TO - 1);
    chk("req_cycles", hi, timed_out ? TO : k + 1);
    chk("req_stable", stable, 1'b1);
    if (timed_out) m_err = 1'b1;
    else if (g) m_drdata = rd;
    else m_irdata = rd;
    chk("i_done", i_done, !g);
    chk("d_done", d_done, g);
    chk("i_rdata", i_rdata, m_irdata);
    chk("d_rdata", d_rdata, m_drdata);
    chk("err", err, m_err);
    chk("done_busy", busy, 1'b1);
    if (g) d_req = 1'b0; else i_req = 1'b0;
    if (spurious) begin mem_ack = 1'b1; mem_rdata = ~rd; end
    tick();
    mem_ack = 1'b0;
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", {i_done, d_done}, 2'b00);
  endtask

  initial begin
    logic [31:0] fa;
    do_reset();

    // Single I read, ack on the third mem_req cycle.
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h0000_0400;
    xfer(2, {32{8'hA5}}, 1'b0, 1'b0, fa);

    // D write: strobe and data held until ack, read data still captured.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000_0020; d_wdata = 256'h1;
    xfer(3, rand256(), 1'b0, 1'b0, fa);

    // Contention straight out of reset must alternate D, I, D, I.
    do_reset();
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h0000_0100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200;
    for (int j = 0; j < 4; j++) begin
      xfer(2, rand256(), 1'b0, 1'b0, fa);
      chk("contention_order", fa, (j % 2 == 0) ? 32'h0000_0200 : 32'h0000_0100);
      if (!i_req) i_req = 1'b1;
      if (!d_req) d_req = 1'b1;
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();

    // Memory never answers: abort after TO cycles, err sticks, next request still served.
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h0000_0300;
    xfer(1000, rand256(), 1'b0, 1'b0, fa);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0340;
    xfer(1, rand256(), 1'b0, 1'b0, fa);

    // Ack exactly on the watchdog's last cycle completes normally.
    do_reset();
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h0000_0500;
    xfer(TO - 1, rand256(), 1'b0, 1'b0, fa);

    // Reset in the middle of a D transfer: mem_req drops immediately, no done pulse.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0600;
    tick();
    tick();
    chk("mid_gnt_req", mem_req, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", mem_req, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    tick();
    chk("mid_rst_done", d_done, 1'b0);
    @(negedge clk);
    d_req = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_done", d_done, 1'b0);
    m_last = 1'b0; m_err = 1'b0; m_irdata = '0; m_drdata = '0;
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h0000_0700;
    xfer(0, rand256(), 1'b0, 1'b0, fa);

    // Randomized traffic: random arrivals, latencies (some past timeout), early drops, stray acks.
    for (int n = 0; n < 40; n++) begin
      if (!i_req && ($urandom % 2 == 1)) raise_i();
      if (!d_req && ($urandom % 2 == 1)) raise_d();
      if (!i_req && !d_req) begin
        if ($urandom % 2 == 1) raise_i(); else raise_d();
      end
      xfer(int'($urandom_range(0, TO + 2)), rand256(), ($urandom % 4) == 0,
           1'($urandom), fa);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
